a2_deser: RTL and testbench
===========================

// Module: a2_deser
// PURPOSE
//   Serial-to-parallel receiver; the stage directly downstream of the A2 serializer.
//   Consumes the serializer's bit stream (ser_data_o / ser_data_val_o) and rebuilds
//   variable-length words. Each received word is emitted with its bit count.
//   A word ends on a gap in the valid strobe or when WIDTH bits have been collected.
// PARAMETERS
//   WIDTH     12  maximum word length in bits; width of deser_data_o
//   VAL_BITS  4   width of the bit-count output; VAL_BITS >= $clog2(WIDTH+1) (elab check)
// PORTS
//   clk_i             in   1         clock; all logic on rising edge
//   arst_n_i          in   1         reset; asynchronous assert, active-low
//   data_i            in   1         serial data bit
//   data_val_i        in   1         data_i is valid this cycle
//   deser_data_o      out  WIDTH     reassembled word, right-aligned, unused MSBs = 0
//   deser_data_mod_o  out  VAL_BITS  number of valid bits in deser_data_o (1..WIDTH)
//   deser_data_val_o  out  1         one-cycle pulse: deser_data_o/_mod_o valid
//   busy_o            out  1         a word is being collected (state RECV)
// BEHAVIOUR
//   Reset: deser_data_o=0, deser_data_mod_o=0, deser_data_val_o=0, busy_o=0,
//     state=IDLE, shift reg=0, bit counter=0. A partial word is discarded, never emitted.
//   Sampling: a bit is taken on each rising edge where data_val_i=1. No backpressure;
//     the consumer must accept every deser_data_val_o pulse.
//   FSM (2 states):
//     IDLE: data_val_i=1 -> load first bit, cnt=1, go RECV. Exception: WIDTH==1
//       emits the word on that same edge and stays IDLE.
//     RECV, data_val_i=1, cnt<WIDTH-1 -> shift bit in, cnt++.
//     RECV, data_val_i=1, cnt==WIDTH-1 -> word complete: emit WIDTH bits, clear,
//       go IDLE. A bit valid on the next cycle starts a new word; back-to-back
//       full words therefore need no gap.
//     RECV, data_val_i=0 -> word complete: emit cnt bits, clear, go IDLE.
//   Emit: on the completing edge, register data, mod and val=1. Outputs are visible in
//     the cycle after that edge. val drops the following cycle unless a new word also
//     completes. data/mod hold their last value while val=0.
//   Latency: last bit sampled at edge N -> val high after edge N (full word).
//     Gap-terminated words: val high after edge N+1, the edge that sees data_val_i=0.
//   Bit order (default, macro undefined): MSB-first. Shift-left into a zeroed reg, so
//     for n bits the first bit is deser_data_o[n-1] and the last is [0].
//   busy_o = (state==RECV), registered. It is 0 in the cycle val pulses for a
//     gap-terminated or full word.
//   Count arithmetic: cnt is VAL_BITS wide and never exceeds WIDTH; no wrap-around.
//   A 1-bit word is legal and emits mod=1.
//   X on data_i while data_val_i=0 is ignored.
// CONFIGURATION
//   A2_DESER_LSB_FIRST_EN
//     Defined: LSB-first; bit k of the word (k = 0 for the first bit) is placed in
//       deser_data_o[k]. Bits [WIDTH-1:n] are 0. Matches an LSB-first serializer build.
//     Undefined: MSB-first as in BEHAVIOUR.
//     Timing, count and handshake are identical in both builds.
// TESTING
//   1. Val high 5 cycles, bits 1,0,1,1,0, then val=0
//      -> one pulse: data=12'h016, mod=5, one cycle after the val=0 edge.
//   2. Val high 15 cycles; first 12 bits = 12'hA5C MSB-first, then 1,1,1, then val=0
//      -> pulse data=12'hA5C mod=12; second pulse data=12'h007 mod=3.
//   3. Single-cycle val, bit=1
//      -> data=12'h001, mod=1. Busy high for exactly 1 cycle.
//   4. arst_n_i low after 6 bits received, released, then 3 bits 1,0,1 + gap
//      -> no pulse for the partial word; outputs 0 during reset; then data=12'h005, mod=3.
//   5. With A2_DESER_LSB_FIRST_EN defined, bits 1,0,1,1,0 + gap
//      -> data=12'h00D, mod=5.
//   6. Bursts of 3 and 4 bits separated by a 1-cycle gap, then 12 random words chained
//      to the serializer -> every word/length matches the serializer input
//      (scoreboard); no lost or merged words.

Source files
------------

// File: rtl/a2_deser.sv
// a2_deser: serial-to-parallel receiver rebuilding variable-length words.
// Optional build macro A2_DESER_LSB_FIRST_EN selects LSB-first bit placement.
module a2_deser #(
    parameter int WIDTH    = 12,
    parameter int VAL_BITS = 4
) (
    input  logic                clk_i,
    input  logic                arst_n_i,
    input  logic                data_i,
    input  logic                data_val_i,
    output logic [WIDTH-1:0]    deser_data_o,
    output logic [VAL_BITS-1:0] deser_data_mod_o,
    output logic                deser_data_val_o,
    output logic                busy_o
);

    generate
        if (VAL_BITS < $clog2(WIDTH + 1)) begin : g_bad_val_bits
            $error("a2_deser: VAL_BITS too small for WIDTH");
        end
    endgenerate

    typedef enum logic {
        IDLE,
        RECV
    } state_t;

    state_t              state_q, state_d;
    logic [WIDTH-1:0]    shreg_q, shreg_d;
    logic [VAL_BITS-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0]    data_q;
    logic [VAL_BITS-1:0] mod_q;
    logic                val_q;

    logic                emit;
    logic [WIDTH-1:0]    emit_data;
    logic [VAL_BITS-1:0] emit_mod;
    logic [WIDTH-1:0]    first_bit;
    logic [WIDTH-1:0]    shifted;

    assign first_bit = WIDTH'(data_i);

`ifdef A2_DESER_LSB_FIRST_EN
    assign shifted = shreg_q | (first_bit << cnt_q);
`else
    assign shifted = (shreg_q << 1) | first_bit;
`endif

    always_comb begin
        state_d   = state_q;
        shreg_d   = shreg_q;
        cnt_d     = cnt_q;
        emit      = 1'b0;
        emit_data = shreg_q;
        emit_mod  = cnt_q;
        unique case (state_q)
            IDLE: begin
                if (data_val_i) begin
                    if (WIDTH == 1) begin
                        emit      = 1'b1;
                        emit_data = first_bit;
                        emit_mod  = VAL_BITS'(1);
                    end else begin
                        shreg_d = first_bit;
                        cnt_d   = VAL_BITS'(1);
                        state_d = RECV;
                    end
                end
            end
            RECV: begin
                if (data_val_i) begin
                    if (cnt_q == VAL_BITS'(WIDTH - 1)) begin
                        emit      = 1'b1;
                        emit_data = shifted;
                        emit_mod  = VAL_BITS'(WIDTH);
                        shreg_d   = '0;
                        cnt_d     = '0;
                        state_d   = IDLE;
                    end else begin
                        shreg_d = shifted;
                        cnt_d   = cnt_q + VAL_BITS'(1);
                    end
                end else begin
                    // Gap in the strobe closes the word at its current length.
                    emit    = 1'b1;
                    shreg_d = '0;
                    cnt_d   = '0;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge arst_n_i) begin
        if (!arst_n_i) begin
            state_q <= IDLE;
            shreg_q <= '0;
            cnt_q   <= '0;
            data_q  <= '0;
            mod_q   <= '0;
            val_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            shreg_q <= shreg_d;
            cnt_q   <= cnt_d;
            val_q   <= emit;
            if (emit) begin
                data_q <= emit_data;
                mod_q  <= emit_mod;
            end
        end
    end

    assign deser_data_o     = data_q;
    assign deser_data_mod_o = mod_q;
    assign deser_data_val_o = val_q;
    assign busy_o           = (state_q == RECV);

endmodule

// File: tb/tb_a2_deser.sv
// tb_a2_deser: directed bench for a2_deser with a word-level scoreboard.
// Expected words follow A2_DESER_LSB_FIRST_EN when it is defined.
module tb_a2_deser;

    logic        clk_i;
    logic        arst_n_i;
    logic        data_i;
    logic        data_val_i;
    logic [11:0] deser_data_o;
    logic [3:0]  deser_data_mod_o;
    logic        deser_data_val_o;
    logic        busy_o;

    int n_cmp;
    int n_bad;
    int busy_cnt;

    logic [11:0] got_d[$];
    logic [3:0]  got_m[$];
    logic [11:0] exp_d[$];
    logic [3:0]  exp_m[$];

    a2_deser #(
        .WIDTH   (12),
        .VAL_BITS(4)
    ) u_dut (
        .clk_i           (clk_i),
        .arst_n_i        (arst_n_i),
        .data_i          (data_i),
        .data_val_i      (data_val_i),
        .deser_data_o    (deser_data_o),
        .deser_data_mod_o(deser_data_mod_o),
        .deser_data_val_o(deser_data_val_o),
        .busy_o          (busy_o)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    always @(negedge clk_i) begin
        if (deser_data_val_o === 1'b1) begin
            got_d.push_back(deser_data_o);
            got_m.push_back(deser_data_mod_o);
        end
        if (busy_o === 1'b1) busy_cnt++;
    end

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, want %0h", tag, got, exp);
        end
    endtask

    // Drive one cycle, return at the next falling edge.
    task automatic drive(input logic v, input logic b);
        data_val_i = v;
        data_i     = b;
        @(negedge clk_i);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(1'b0, 1'bx);
    endtask

    // Bits go out value[n-1] first.
    task automatic send_word(input logic [11:0] v, input int n);
        for (int i = n - 1; i >= 0; i--) drive(1'b1, v[i]);
    endtask

    function automatic logic [11:0] model(input logic [11:0] v, input int n);
        logic [11:0] r;
        r = '0;
`ifdef A2_DESER_LSB_FIRST_EN
        for (int k = 0; k < n; k++) r[k] = v[n-1-k];
`else
        for (int k = 0; k < n; k++) r[k] = v[k];
`endif
        return r;
    endfunction

    task automatic flush();
        got_d.delete();
        got_m.delete();
        exp_d.delete();
        exp_m.delete();
    endtask

    task automatic expect_word(input logic [11:0] d, input logic [3:0] m);
        exp_d.push_back(d);
        exp_m.push_back(m);
    endtask

    task automatic score(input string tag);
        int n;
        chk({tag, "_count"}, got_d.size(), exp_d.size());
        n = (got_d.size() < exp_d.size()) ? got_d.size() : exp_d.size();
        for (int i = 0; i < n; i++) begin
            chk($sformatf("%s_data%0d", tag, i), got_d[i], exp_d[i]);
            chk($sformatf("%s_mod%0d", tag, i), got_m[i], exp_m[i]);
        end
    endtask

    initial begin
        logic [11:0] rv;
        int          rl;
        n_cmp      = 0;
        n_bad      = 0;
        busy_cnt   = 0;
        arst_n_i   = 1'b0;
        data_val_i = 1'b0;
        data_i     = 1'b0;
        repeat (2) @(negedge clk_i);
        chk("rst_data", deser_data_o, 0);
        chk("rst_mod", deser_data_mod_o, 0);
        chk("rst_val", deser_data_val_o, 0);
        chk("rst_busy", busy_o, 0);
        arst_n_i = 1'b1;
        idle(2);

        // 1: five bits then a gap
        flush();
        send_word(12'b10110, 5);
        chk("t1_busy", busy_o, 1);
        chk("t1_early", deser_data_val_o, 0);
        drive(1'b0, 1'bx);
        chk("t1_val", deser_data_val_o, 1);
        chk("t1_busy_end", busy_o, 0);
`ifdef A2_DESER_LSB_FIRST_EN
        chk("t1_data", deser_data_o, 12'h00D);
`else
        chk("t1_data", deser_data_o, 12'h016);
`endif
        chk("t1_mod", deser_data_mod_o, 5);
        drive(1'b0, 1'bx);
        chk("t1_val_drop", deser_data_val_o, 0);
        chk("t1_hold", deser_data_mod_o, 5);
        idle(2);
        chk("t1_pulses", got_d.size(), 1);

        // 2: full word, no gap, then three more bits
        flush();
        send_word(12'hA5C, 12);
        chk("t2_full_val", deser_data_val_o, 1);
        chk("t2_full_busy", busy_o, 0);
        send_word(12'h007, 3);
        idle(3);
`ifdef A2_DESER_LSB_FIRST_EN
        expect_word(12'h3A5, 4'd12);
`else
        expect_word(12'hA5C, 4'd12);
`endif
        expect_word(12'h007, 4'd3);
        score("t2");

        // 3: single-bit word
        flush();
        busy_cnt = 0;
        drive(1'b1, 1'b1);
        drive(1'b0, 1'bx);
        idle(3);
        expect_word(12'h001, 4'd1);
        score("t3");
        chk("t3_busy_cycles", busy_cnt, 1);

        // 4: reset in the middle of a word
        flush();
        send_word(12'b101101, 6);
        chk("t4_busy_pre", busy_o, 1);
        #1;
        arst_n_i   = 1'b0;
        data_val_i = 1'b0;
        @(negedge clk_i);
        chk("t4_rst_data", deser_data_o, 0);
        chk("t4_rst_mod", deser_data_mod_o, 0);
        chk("t4_rst_val", deser_data_val_o, 0);
        chk("t4_rst_busy", busy_o, 0);
        arst_n_i = 1'b1;
        idle(2);
        send_word(12'b101, 3);
        idle(3);
        expect_word(12'h005, 4'd3);
        score("t4");

        // 6: short bursts, then a scoreboarded stream
        flush();
        send_word(12'b110, 3);
        drive(1'b0, 1'bx);
        send_word(12'b1001, 4);
        drive(1'b0, 1'bx);
        expect_word(model(12'b110, 3), 4'd3);
        expect_word(model(12'b1001, 4), 4'd4);
        for (int i = 0; i < 12; i++) begin
            rl = (i % 4 == 0) ? 12 : int'($urandom_range(1, 12));
            rv = 12'($urandom);
            send_word(rv, rl);
            if (rl != 12) drive(1'b0, 1'bx);
            expect_word(model(rv, rl), 4'(rl));
        end
        idle(4);
        score("t6");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
